// File: rtl/cpld_ram_pkg.sv
// Shared types and widths for the expansion-SRAM host arbiter.
// The FSM encoding, counter widths and SRAM address split live here.
package cpld_ram_pkg;

    localparam int unsigned ADR_W     = 19;
    localparam int unsigned ADRHI_W   = 5;
    localparam int unsigned ADRHI_LSB = ADR_W - ADRHI_W;
    localparam int unsigned WIN_W     = 8;
    localparam int unsigned ACC_W     = 8;
    localparam int unsigned STARVE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cpld_ram_window_det.sv
// Samples Z80 MREQ* on every clk edge and reports when the bus has been
// idle for at least WIN_MIN consecutive edges.
module cpld_ram_window_det
    import cpld_ram_pkg::*;
#(
    parameter int unsigned WIN_MIN = 1
) (
    input  logic i_clk,
    input  logic i_reset_b,
    input  logic i_mreq_b,
    output logic o_win_ok
);

    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(WIN_MIN);

    logic [WIN_W-1:0] r_win_cnt;

    always_ff @(posedge i_clk or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_win_cnt <= '0;
        end else if (!i_mreq_b) begin
            r_win_cnt <= '0;
        end else if (r_win_cnt < WIN_MAX) begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
    end

    assign o_win_ok = (r_win_cnt >= WIN_MAX);

endmodule

// File: rtl/cpld_ram_host_arbiter.sv
// Shares the expansion SRAM between the Z80 (absolute priority) and a host
// port; host cycles slot into MREQ*-idle windows and abort on a CPU cycle.
module cpld_ram_host_arbiter
    import cpld_ram_pkg::*;
#(
    parameter int unsigned ACC_CYCLES   = 2,
    parameter int unsigned WIN_MIN      = 1,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               mreq_b,
    input  logic               cpu_ramcs_b,
    input  logic [ADRHI_W-1:0] cpu_ramadrhi,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADR_W-1:0]   host_adr,
    input  logic [7:0]         host_wdata,
    output logic               host_ack,
    output logic [7:0]         host_rdata,
    output logic               host_starved,
    output logic               sram_cs_b,
    output logic               sram_oe_b,
    output logic               sram_we_b,
    output logic [ADRHI_W-1:0] sram_adrhi,
    output logic               host_bus_oe,
    input  logic [7:0]         sram_data_in,
    output logic               sram_data_oe
);

    localparam logic [ACC_W-1:0]    ACC_INIT   = ACC_W'(ACC_CYCLES - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'((STARVE_LIMIT > 255) ? 255 : STARVE_LIMIT);
    localparam bit                  WE_FULL    = (ACC_CYCLES == 1);

    arb_state_t          r_state, w_state_nxt;
    logic                r_we;
    logic [ADRHI_W-1:0]  r_adrhi;
    logic [ACC_W-1:0]    r_acc_cnt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [STARVE_W-1:0] w_starve_inc;
    logic                r_starved;
    logic [7:0]          r_rdata;
    logic                w_win_ok;
    logic                w_acc_last;
    logic                w_busy;
    logic                w_unused;

    cpld_ram_window_det #(
        .WIN_MIN (WIN_MIN)
    ) u_window_det (
        .i_clk     (clk),
        .i_reset_b (reset_b),
        .i_mreq_b  (mreq_b),
        .o_win_ok  (w_win_ok)
    );

    assign w_acc_last   = (r_acc_cnt == '0);
    assign w_busy       = (r_state == ST_WAIT) || (r_state == ST_ACCESS);
    assign w_starve_inc = (r_starve_cnt == '1) ? r_starve_cnt : r_starve_cnt + STARVE_W'(1);
    // Low address bits and write data reach the SRAM via the external buffers.
    assign w_unused     = ^{host_adr[ADRHI_LSB-1:0], host_wdata};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (host_req) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!host_req)                w_state_nxt = ST_IDLE;
                else if (w_win_ok && mreq_b)  w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!mreq_b)         w_state_nxt = ST_WAIT;
                else if (w_acc_last) w_state_nxt = ST_DONE;
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_we         <= 1'b0;
            r_adrhi      <= '0;
            r_acc_cnt    <= '0;
            r_starve_cnt <= '0;
            r_starved    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (r_state == ST_IDLE && host_req) begin
                r_we    <= host_we;
                r_adrhi <= host_adr[ADR_W-1:ADRHI_LSB];
            end
            if (r_state == ST_WAIT && w_state_nxt == ST_ACCESS)
                r_acc_cnt <= ACC_INIT;
            else if (r_state == ST_ACCESS && mreq_b && !w_acc_last)
                r_acc_cnt <= r_acc_cnt - ACC_W'(1);
            if (r_state == ST_ACCESS && w_state_nxt == ST_DONE && !r_we)
                r_rdata <= sram_data_in;
            if (r_state == ST_IDLE) r_starve_cnt <= '0;
            else if (w_busy)        r_starve_cnt <= w_starve_inc;
            // Completion wins over a same-edge starve set so the ack cycle shows it cleared.
            if (r_state == ST_ACCESS && w_state_nxt == ST_DONE) r_starved <= 1'b0;
            else if (w_busy && w_starve_inc >= STARVE_MAX)      r_starved <= 1'b1;
        end
    end

    always_comb begin
        host_ack     = (r_state == ST_DONE);
        sram_cs_b    = cpu_ramcs_b;
        sram_adrhi   = cpu_ramadrhi;
        sram_oe_b    = 1'b1;
        sram_we_b    = 1'b1;
        host_bus_oe  = 1'b0;
        sram_data_oe = 1'b0;
        if (r_state == ST_ACCESS && mreq_b) begin
            sram_cs_b   = 1'b0;
            sram_adrhi  = r_adrhi;
            host_bus_oe = 1'b1;
            if (r_we) begin
                sram_data_oe = 1'b1;
                sram_we_b    = w_acc_last && !WE_FULL;
            end else begin
                sram_oe_b = 1'b0;
            end
        end
    end

    assign host_rdata   = r_rdata;
    assign host_starved = r_starved;

endmodule

// File: tb/tb_cpld_ram_host_arbiter.sv
// Randomised and directed bench for cpld_ram_host_arbiter against an SRAM
// model and a transaction-level reference of host reads/writes.
module tb_cpld_ram_host_arbiter;

    localparam int unsigned ACC_CYCLES   = 2;
    localparam int unsigned WIN_MIN      = 1;
    localparam int unsigned STARVE_LIMIT = 255;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        mreq_b, cpu_ramcs_b;
    logic [4:0]  cpu_ramadrhi;
    logic        host_req, host_we;
    logic [18:0] host_adr;
    logic [7:0]  host_wdata;
    logic        host_ack, host_starved;
    logic [7:0]  host_rdata;
    logic        sram_cs_b, sram_oe_b, sram_we_b, host_bus_oe, sram_data_oe;
    logic [4:0]  sram_adrhi;
    logic [7:0]  sram_data_in;

    logic        rand_mode = 1'b0;
    logic        dir_mreq, dir_cs, rnd_mreq = 1'b1, rnd_cs = 1'b1;
    logic [4:0]  dir_adrhi, rnd_adrhi = 5'h0;

    int unsigned n_checks = 0, n_errors = 0;
    int unsigned m_bus = 0, m_ack = 0, m_bad = 0;

    logic [7:0] mem_w  [logic [18:0]];
    logic [7:0] ref_wr [logic [18:0]];

    int unsigned t_got, t_lat, t_cs, t_oe, t_we, t_doe, t_hcyc, t_we_first, t_we_last;
    logic [4:0]  t_adrhi;
    logic [7:0]  t_rdata;
    logic        t_starved;

    always #5 clk = ~clk;

    assign mreq_b       = rand_mode ? rnd_mreq  : dir_mreq;
    assign cpu_ramcs_b  = rand_mode ? rnd_cs    : dir_cs;
    assign cpu_ramadrhi = rand_mode ? rnd_adrhi : dir_adrhi;

    cpld_ram_host_arbiter #(
        .ACC_CYCLES   (ACC_CYCLES),
        .WIN_MIN      (WIN_MIN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .mreq_b       (mreq_b),
        .cpu_ramcs_b  (cpu_ramcs_b),
        .cpu_ramadrhi (cpu_ramadrhi),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_adr     (host_adr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .host_starved (host_starved),
        .sram_cs_b    (sram_cs_b),
        .sram_oe_b    (sram_oe_b),
        .sram_we_b    (sram_we_b),
        .sram_adrhi   (sram_adrhi),
        .host_bus_oe  (host_bus_oe),
        .sram_data_in (sram_data_in),
        .sram_data_oe (sram_data_oe)
    );

    function automatic logic [7:0] init_byte(input logic [18:0] a);
        logic [18:0] t;
        t = a * 19'd37;
        return t[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    // SRAM model: address high bits from the pins, low bits from the host buffers.
    logic [18:0] sram_addr;
    assign sram_addr = {sram_adrhi, host_bus_oe ? host_adr[13:0] : 14'h0};

    function automatic logic [7:0] sram_rd(input logic [18:0] a, input logic cs_b, input logic oe_b);
        if (!cs_b && !oe_b) return mem_w.exists(a) ? mem_w[a] : init_byte(a);
        return 8'hEE;
    endfunction

    assign sram_data_in = sram_rd(sram_addr, sram_cs_b, sram_oe_b);

    initial forever begin
        @(negedge clk); #1;
        if (!sram_cs_b && !sram_we_b && sram_data_oe && host_bus_oe)
            mem_w[sram_addr] = host_wdata;
    end

    function automatic logic [7:0] exp_byte(input logic [18:0] a);
        return ref_wr.exists(a) ? ref_wr[a] : init_byte(a);
    endfunction

    function automatic logic [11:0] pins();
        return {host_ack, host_starved, sram_cs_b, sram_oe_b, sram_we_b, host_bus_oe,
                sram_data_oe, sram_adrhi};
    endfunction

    function automatic logic [11:0] idle_pins(input logic st);
        return {1'b0, st, cpu_ramcs_b, 1'b1, 1'b1, 1'b0, 1'b0, cpu_ramadrhi};
    endfunction

    initial forever begin
        @(negedge clk); #2;
        m_bus += host_bus_oe;
        m_ack += host_ack;
        if (!mreq_b && pins() != {host_ack, host_starved, idle_pins(1'b0)[9:0]}) m_bad++;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_mode) begin
            rnd_mreq  = ($urandom_range(0, 9) >= 3);
            rnd_cs    = $urandom_range(0, 1) == 1;
            rnd_adrhi = 5'($urandom_range(0, 31));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic host_xfer(input logic we, input logic [18:0] adr, input logic [7:0] wd,
                             input int unsigned budget);
        host_we = we; host_adr = adr; host_wdata = wd; host_req = 1'b1;
        t_got = 0; t_lat = 0; t_cs = 0; t_oe = 0; t_we = 0; t_doe = 0; t_hcyc = 0;
        t_we_first = 0; t_we_last = 0; t_adrhi = '0; t_rdata = '0; t_starved = 1'b0;
        for (int unsigned i = 1; i <= budget && t_got == 0; i++) begin
            @(negedge clk);
            if (host_bus_oe) begin
                t_cs  += !sram_cs_b;
                t_oe  += !sram_oe_b;
                t_we  += !sram_we_b;
                t_doe += sram_data_oe;
                t_adrhi = sram_adrhi;
                if (t_hcyc == 0) t_we_first = !sram_we_b;
                t_we_last = !sram_we_b;
                t_hcyc++;
            end
            if (host_ack) begin
                t_got = 1; t_lat = i; t_rdata = host_rdata; t_starved = host_starved;
            end
        end
        host_req = 1'b0;
        chk_eq("xfer_ack", t_got, 1);
        if (t_got != 0) begin
            if (we) ref_wr[adr] = wd;
            @(negedge clk);
            chk_eq("ack_pulse", host_ack, 0);
        end
    endtask

    initial begin
        int unsigned snap_bus, snap_ack, found, acks, bus_seen;
        logic        st255, st256;
        logic [18:0] pool [8];
        logic [18:0] a;
        logic        w;

        reset_b = 1'b0; host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_wdata = '0;
        dir_mreq = 1'b1; dir_cs = 1'b0; dir_adrhi = 5'h0A;
        repeat (3) @(negedge clk);
        chk_eq("reset_pins", pins(), idle_pins(1'b0));
        chk_eq("reset_rdata", host_rdata, 0);
        dir_cs = 1'b1; dir_adrhi = 5'h03; reset_b = 1'b1;
        repeat (4) @(negedge clk);
        chk_eq("idle_pins", pins(), idle_pins(1'b0));

        // Read with the bus idle: one edge to register, one grant edge, ACC_CYCLES access edges.
        host_xfer(1'b0, 19'h4C123, 8'h00, 20);
        chk_eq("rd_latency", t_lat, 2 + ACC_CYCLES);
        chk_eq("rd_cs_cycles", t_cs, ACC_CYCLES);
        chk_eq("rd_oe_cycles", t_oe, ACC_CYCLES);
        chk_eq("rd_we_cycles", t_we, 0);
        chk_eq("rd_adrhi", t_adrhi, 5'b10011);
        chk_eq("rd_data", t_rdata, exp_byte(19'h4C123));

        host_xfer(1'b1, 19'h00010, 8'h5A, 20);
        chk_eq("wr_we_cycles", t_we, ACC_CYCLES - 1);
        chk_eq("wr_we_first", t_we_first, 1);
        chk_eq("wr_we_last", t_we_last, 0);
        chk_eq("wr_doe_cycles", t_doe, ACC_CYCLES);
        chk_eq("wr_oe_cycles", t_oe, 0);
        chk_eq("wr_adrhi", t_adrhi, 5'h00);
        chk_eq("wr_mem", mem_w.exists(19'h00010) ? mem_w[19'h00010] : 8'h00, 8'h5A);
        host_xfer(1'b0, 19'h00010, 8'h00, 20);
        chk_eq("wr_readback", t_rdata, 8'h5A);

        // CPU cycle starts during the first access cycle: pins hand back immediately.
        host_we = 1'b1; host_adr = 19'h25555; host_wdata = 8'hC3; host_req = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (host_bus_oe) found = 1;
        end
        chk_eq("abort_grant", found, 1);
        dir_mreq = 1'b0; dir_cs = 1'b0; dir_adrhi = 5'h07;
        #1;
        chk_eq("abort_pins", pins(), idle_pins(1'b0));
        snap_ack = m_ack;
        repeat (3) @(negedge clk);
        chk_eq("abort_no_ack", m_ack - snap_ack, 0);
        dir_mreq = 1'b1; dir_cs = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (host_ack) begin acks++; host_req = 1'b0; end
        end
        chk_eq("abort_retry_acks", acks, 1);
        ref_wr[19'h25555] = 8'hC3;
        host_xfer(1'b0, 19'h25555, 8'h00, 20);
        chk_eq("abort_readback", t_rdata, exp_byte(19'h25555));

        // Request cancelled while the CPU holds the bus.
        dir_mreq = 1'b0; dir_cs = 1'b0; dir_adrhi = 5'h11;
        snap_bus = m_bus; snap_ack = m_ack;
        host_we = 1'b1; host_adr = 19'h7FFFF; host_wdata = 8'h99; host_req = 1'b1;
        repeat (5) @(negedge clk);
        host_req = 1'b0;
        repeat (2) @(negedge clk);
        dir_mreq = 1'b1; dir_cs = 1'b1;
        repeat (5) @(negedge clk);
        chk_eq("cancel_no_bus", m_bus - snap_bus, 0);
        chk_eq("cancel_no_ack", m_ack - snap_ack, 0);
        host_xfer(1'b0, 19'h7FFFF, 8'h00, 20);
        chk_eq("cancel_no_write", t_rdata, exp_byte(19'h7FFFF));

        // MREQ* low every other edge never leaves a usable window.
        dir_mreq = 1'b0; host_we = 1'b0; host_adr = 19'h30F0F; host_req = 1'b1;
        snap_ack = m_ack; bus_seen = 0; st255 = 1'b0; st256 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            bus_seen += host_bus_oe;
            if (k == STARVE_LIMIT)     st255 = host_starved;
            if (k == STARVE_LIMIT + 1) st256 = host_starved;
            dir_mreq = ~dir_mreq;
        end
        chk_eq("starve_no_grant", bus_seen, 0);
        chk_eq("starve_no_ack", m_ack - snap_ack, 0);
        chk_eq("starve_before", st255, 0);
        chk_eq("starve_set", st256, 1);
        dir_mreq = 1'b1;
        host_xfer(1'b0, 19'h30F0F, 8'h00, 10);
        chk_eq("starve_clr_at_ack", t_starved, 0);
        chk_eq("starve_clr_after", host_starved, 0);
        chk_eq("starve_rdata", t_rdata, exp_byte(19'h30F0F));

        // Reset in the middle of a write.
        host_we = 1'b1; host_adr = 19'h12345; host_wdata = 8'h77; host_req = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (host_bus_oe) found = 1;
        end
        chk_eq("rst_grant", found, 1);
        reset_b = 1'b0; host_req = 1'b0;
        #1;
        chk_eq("rst_async_pins", pins(), idle_pins(1'b0));
        chk_eq("rst_async_rdata", host_rdata, 0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        snap_bus = m_bus; snap_ack = m_ack;
        repeat (4) @(negedge clk);
        chk_eq("rst_idle_bus", m_bus - snap_bus, 0);
        chk_eq("rst_idle_ack", m_ack - snap_ack, 0);
        host_xfer(1'b0, 19'h00010, 8'h00, 20);
        chk_eq("rst_after_read", t_rdata, 8'h5A);

        // Random CPU traffic with host transactions on a small address pool.
        for (int i = 0; i < 8; i++) pool[i] = 19'($urandom);
        rand_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = pool[$urandom_range(0, 7)];
            w = $urandom_range(0, 1) == 1;
            host_xfer(w, a, 8'($urandom), 400);
            if (!w) chk_eq("rand_rdata", t_rdata, exp_byte(a));
        end
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("cpu_passthru", m_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
